// File: rtl/unidade_controle_jogada.sv
// Moore control unit for the play datapath: start, clear, wait/register/compare/advance loop.
// Optional inactivity timeout in `espera` is compiled in only when UC_TIMEOUT_EN is defined.
module unidade_controle_jogada #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  output logic       zera_contador,
  output logic       conta_contador,
  output logic       zera_registrador,
  output logic       registra,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    Inicial    = 4'b0000,
    Preparacao = 4'b0001,
    Espera     = 4'b0010,
    Registra   = 4'b0100,
    Comparacao = 4'b0101,
    Proximo    = 4'b0110,
    FimAcerto  = 4'b1010,
    FimErro    = 4'b1110,
    FimTimeout = 4'b1101
  } estado_t;

  estado_t estado_q, estado_d;
  logic    jogada_q;
  logic    borda;
  logic    timeout_hit;
  logic    zera_d, conta_d, registra_d, pronto_d, acertou_d, errou_d, timeout_d;

  // Only a fresh press counts; a level held from before `espera` is ignored.
  assign borda = jogada & ~jogada_q;

`ifdef UC_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (estado_q == Espera) begin
      cnt_q <= cnt_q + CntW'(1);
    end else begin
      cnt_q <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    estado_d = Inicial;
    case (estado_q)
      Inicial:    estado_d = iniciar ? Preparacao : Inicial;
      Preparacao: estado_d = Espera;
      Espera: begin
        if (borda) begin
          estado_d = Registra;
        end else if (timeout_hit) begin
          estado_d = FimTimeout;
        end else begin
          estado_d = Espera;
        end
      end
      Registra:   estado_d = Comparacao;
      Comparacao: begin
        if (!igual) begin
          estado_d = FimErro;
        end else if (fim_contagem) begin
          estado_d = FimAcerto;
        end else begin
          estado_d = Proximo;
        end
      end
      Proximo:    estado_d = Espera;
      FimAcerto:  estado_d = iniciar ? Preparacao : FimAcerto;
      FimErro:    estado_d = iniciar ? Preparacao : FimErro;
`ifdef UC_TIMEOUT_EN
      FimTimeout: estado_d = iniciar ? Preparacao : FimTimeout;
`endif
      default:    estado_d = Inicial;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with estado_q.
  always_comb begin
    zera_d     = 1'b0;
    conta_d    = 1'b0;
    registra_d = 1'b0;
    pronto_d   = 1'b0;
    acertou_d  = 1'b0;
    errou_d    = 1'b0;
    timeout_d  = 1'b0;
    case (estado_d)
      Preparacao: zera_d     = 1'b1;
      Registra:   registra_d = 1'b1;
      Proximo:    conta_d    = 1'b1;
      FimAcerto: begin
        pronto_d  = 1'b1;
        acertou_d = 1'b1;
      end
      FimErro: begin
        pronto_d = 1'b1;
        errou_d  = 1'b1;
      end
`ifdef UC_TIMEOUT_EN
      FimTimeout: begin
        pronto_d  = 1'b1;
        timeout_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q         <= Inicial;
      jogada_q         <= 1'b0;
      zera_contador    <= 1'b0;
      zera_registrador <= 1'b0;
      conta_contador   <= 1'b0;
      registra         <= 1'b0;
      pronto           <= 1'b0;
      acertou          <= 1'b0;
      errou            <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      jogada_q         <= jogada;
      zera_contador    <= zera_d;
      zera_registrador <= zera_d;
      conta_contador   <= conta_d;
      registra         <= registra_d;
      pronto           <= pronto_d;
      acertou          <= acertou_d;
      errou            <= errou_d;
    end
  end

`ifdef UC_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout_d;
  assign unused_timeout_d = timeout_d;
`endif

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogada.sv
// Directed bench for unidade_controle_jogada; timeout checks follow UC_TIMEOUT_EN.
module tb_unidade_controle_jogada;

  logic       clock, reset, iniciar, jogada, igual, fim_contagem;
  logic       zera_contador, conta_contador, zera_registrador, registra;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic [7:0] outs;

  int n_vec = 0;
  int n_err = 0;

  // {zera_contador, zera_registrador, registra, conta_contador, pronto, acertou, errou, timeout}
  localparam logic [7:0] ONone = 8'b0000_0000;
  localparam logic [7:0] OPrep = 8'b1100_0000;
  localparam logic [7:0] OReg  = 8'b0010_0000;
  localparam logic [7:0] OProx = 8'b0001_0000;
  localparam logic [7:0] OAcer = 8'b0000_1100;
  localparam logic [7:0] OErro = 8'b0000_1010;
  localparam logic [7:0] OTout = 8'b0000_1001;

  unidade_controle_jogada #(.TIMEOUT_CYCLES(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .jogada           (jogada),
    .igual            (igual),
    .fim_contagem     (fim_contagem),
    .zera_contador    (zera_contador),
    .conta_contador   (conta_contador),
    .zera_registrador (zera_registrador),
    .registra         (registra),
    .pronto           (pronto),
    .acertou          (acertou),
    .errou            (errou),
    .timeout          (timeout),
    .db_estado        (db_estado)
  );

  assign outs = {zera_contador, zera_registrador, registra, conta_contador,
                 pronto, acertou, errou, timeout};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [7:0] o);
    check({tag, " estado"}, {28'd0, db_estado}, {28'd0, st});
    check({tag, " saidas"}, {24'd0, outs}, {24'd0, o});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim_contagem = 1'b0;
    #2;
    expect_st("reset", 4'b0000, ONone);
    step();
    reset = 1'b1;
    step();
    expect_st("inicial", 4'b0000, ONone);

    // Start pulse and clear
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_st("prep", 4'b0001, OPrep);
    step();
    expect_st("espera", 4'b0010, ONone);

    // Normal non-final round
    jogada = 1'b1; igual = 1'b1; fim_contagem = 1'b0;
    step(); expect_st("registra", 4'b0100, OReg);
    step(); expect_st("comparacao", 4'b0101, ONone);
    step(); expect_st("proximo", 4'b0110, OProx);
    step(); expect_st("volta espera", 4'b0010, ONone);

    // Held play must not retrigger
    for (int i = 0; i < 3; i++) begin
      step(); expect_st("segurada", 4'b0010, ONone);
    end
    jogada = 1'b0;
    step(); expect_st("solta", 4'b0010, ONone);
    jogada = 1'b1;
    step(); expect_st("repress", 4'b0100, OReg);
    step(); expect_st("comp2", 4'b0101, ONone);

    // Mismatch ends in fim_erro and holds
    igual = 1'b0;
    step(); expect_st("fim_erro", 4'b1110, OErro);
    for (int i = 0; i < 10; i++) begin
      step(); expect_st("erro hold", 4'b1110, OErro);
    end
    iniciar = 1'b1; jogada = 1'b0;
    step();
    iniciar = 1'b0;
    expect_st("restart", 4'b0001, OPrep);
    step(); expect_st("espera2", 4'b0010, ONone);

    // Last address matches -> fim_acerto
    jogada = 1'b1; igual = 1'b1; fim_contagem = 1'b1;
    step(); expect_st("registra3", 4'b0100, OReg);
    step(); expect_st("comp3", 4'b0101, ONone);
    step(); expect_st("fim_acerto", 4'b1010, OAcer);
    jogada = 1'b0; fim_contagem = 1'b0;
    step(); expect_st("acerto hold", 4'b1010, OAcer);

    // Inactivity in espera
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    expect_st("prep4", 4'b0001, OPrep);
    step(); expect_st("espera4", 4'b0010, ONone);
`ifdef UC_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step(); expect_st("espera tout", 4'b0010, ONone);
    end
    step(); expect_st("fim_timeout", 4'b1101, OTout);
    step(); expect_st("tout hold", 4'b1101, OTout);

    // Edge on the last cycle wins over timeout
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step(); expect_st("espera5", 4'b0010, ONone);
    for (int i = 1; i < 8; i++) begin
      step(); expect_st("espera pre", 4'b0010, ONone);
    end
    jogada = 1'b1;
    step(); expect_st("borda prio", 4'b0100, OReg);
    step(); expect_st("comp5", 4'b0101, ONone);
    jogada = 1'b0;
`else
    for (int i = 0; i < 50; i++) begin
      step(); expect_st("sem timeout", 4'b0010, ONone);
    end
    jogada = 1'b1;
    step(); expect_st("registra5", 4'b0100, OReg);
    step(); expect_st("comp5", 4'b0101, ONone);
    jogada = 1'b0;
`endif

    // Asynchronous reset in comparacao
    #1;
    reset = 1'b0;
    #1;
    expect_st("reset async", 4'b0000, ONone);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); expect_st("pos reset", 4'b0000, ONone);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_jogada.md
# unidade_controle_jogada

Moore-type control unit that sequences the play datapath: sequence address counter, 16x4 expected-value memory, play register and comparator. It waits for `iniciar`, clears the datapath, then loops: waits for a play, registers it, compares it with memory, and advances the address. It ends on the first mismatch, after the last address, or on inactivity timeout. It sits beside the datapath inside the experiment top level and drives its enables and `db_estado`.

## Interface
- `TIMEOUT_CYCLES`, default 5000: cycles allowed in `espera` before timeout (≥2); bench uses 8.
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start/restart request, level-sampled.
- `jogada`  in  1  level, high while any switch pressed (OR of `chaves`).
- `igual`  in  1  comparator result, registered play == memory word.
- `fim_contagem`  in  1  counter at last address (15).
- `zera_contador`  out  1  synchronous clear of address counter.
- `conta_contador`  out  1  counter increment enable.
- `zera_registrador`  out  1  synchronous clear of play register.
- `registra`  out  1  load enable of play register.
- `pronto`  out  1  high in any final state.
- `acertou`  out  1  high in `fim_acerto`.
- `errou`  out  1  high in `fim_erro`.
- `timeout`  out  1  high in `fim_timeout`.
- `db_estado`  out  4  current state code.

## Operation
- State codes:
  - `inicial` 0000
  - `preparacao` 0001
  - `espera` 0010
  - `registra` 0100
  - `comparacao` 0101
  - `proximo` 0110
  - `fim_acerto` 1010
  - `fim_erro` 1110
  - `fim_timeout` 1101
  - Unused codes go to `inicial` on the next edge.
- Transitions:
  - `inicial`: `iniciar`=1 → `preparacao`; else stay.
  - `preparacao`: always → `espera`.
  - `espera`: play edge → `registra`; timeout hit (see below) → `fim_timeout`; else stay.
  - `registra`: always → `comparacao`.
  - `comparacao`: `igual`=0 → `fim_erro`; `igual`=1 and `fim_contagem`=1 → `fim_acerto`; `igual`=1 and `fim_contagem`=0 → `proximo`.
  - `proximo`: always → `espera`.
  - Final states: `iniciar`=1 → `preparacao`; else hold.
- Outputs are decoded from the state register only (pure Moore, no input-to-output path):
  - `zera_contador` = `zera_registrador` = 1 only in `preparacao`.
  - `registra` = 1 only in `registra`.
  - `conta_contador` = 1 only in `proximo`.
  - `pronto` = 1 in all three final states; each flag is high only in its own final state.
- Play edge detector:
  - Register `jogada_d` samples `jogada` every cycle; reset value 0.
  - Edge = `jogada & ~jogada_d`.
  - A play held high while entering `espera` does not count; it must be released and pressed again.
  - Edges occurring outside `espera` are discarded.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES); cleared in every state except `espera`; increments each cycle in `espera`.
  - Timeout hit = count == TIMEOUT_CYCLES-1 with no edge in the same cycle. A simultaneous play edge has priority → `registra`.
- Reset:
  - `reset`=0 forces state `inicial`, `jogada_d`=0 and timeout count 0 immediately, independent of `clock`, including mid-sequence.
  - All outputs are 0 during and after reset; `db_estado` = 0000.

## Timing
- `iniciar` high at edge k in `inicial`/final state → `preparacao` during cycle k..k+1 → `espera` after k+1.
- Play edge sampled at edge k in `espera`:
  - `registra` after k.
  - `comparacao` after k+1.
  - `proximo`/final state after k+2.
  - `espera` again after k+3 (non-final path).
- `igual` and `fim_contagem` must be valid at the edge that ends `comparacao`, i.e. one cycle after the `registra` pulse.
- All enables are single-cycle pulses except final-state outputs, which hold until `iniciar` or reset.
- Timeout: with no edge, `fim_timeout` is entered exactly TIMEOUT_CYCLES edges after entering `espera`.

## Configuration
- `UC_TIMEOUT_EN` defined: timeout counter, `fim_timeout` state and `timeout` output are active as described.
- Not defined:
  - No counter logic is compiled.
  - `espera` waits indefinitely for a play.
  - `timeout` is tied to 0.
  - `fim_timeout` is unreachable; its code is treated as unused.

## Test plan
- `reset`=0 asserted mid-sequence in `comparacao` → `db_estado`=0000 and all outputs 0 before the next clock edge; stays `inicial` with `iniciar`=0 for 5 cycles.
- `iniciar` pulse of 1 cycle → `db_estado` 0001 for exactly one cycle with `zera_contador`=`zera_registrador`=1, then 0010.
- In `espera`, `jogada` 0→1 with `igual`=1, `fim_contagem`=0 → states 0100, 0101, 0110, 0010 on consecutive cycles; `registra` and `conta_contador` are each high for one cycle.
- `jogada` held high across the return to `espera` → stays 0010 until release and re-press; re-press then gives 0100.
- `igual`=0 at `comparacao` → 1110, `pronto`=`errou`=1 held 10 cycles; `iniciar` pulse → 0001. With `igual`=1, `fim_contagem`=1 → 1010, `acertou`=1.
- TIMEOUT_CYCLES=8, `UC_TIMEOUT_EN` defined, no play → 1101 with `timeout`=`pronto`=1 after 8 cycles in 0010. Play edge on the 8th cycle → 0100 instead. Macro undefined → remains 0010 for 50 cycles with `timeout`=0.
